// File: rtl/hazard_forwarding_scoreboard.sv
// EX-stage forwarding and load-use hazard unit backed by a shift-register scoreboard
// of in-flight destination registers, with registered per-operand forwarding selects.
module hazard_forwarding_scoreboard #(
    parameter  int NB_REG     = 5,
    parameter  int N_SRC      = 2,
    parameter  int N_STAGES   = 3,
    parameter  int LOAD_STAGE = 2,
    parameter  int NB_CNT     = 16,
    localparam int NB_SEL     = $clog2(N_STAGES + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid_ID,
    input  logic [N_SRC*NB_REG-1:0] i_rs_from_ID,
    input  logic [N_SRC-1:0]        i_src_used,
    input  logic [NB_REG-1:0]       i_rd_from_ID,
    input  logic                    i_RegWrite_from_ID,
    input  logic                    i_MemRead_from_ID,
    input  logic                    i_flush,
    output logic                    o_stall,
    output logic [N_SRC*NB_SEL-1:0] o_fwd_sel,
    output logic [NB_CNT-1:0]       o_stall_count
);

    typedef struct packed {
        logic [NB_REG-1:0] rd;
        logic              regWrite;
        logic              memRead;
    } sbEntry_t;

    sbEntry_t                       r_sb [N_STAGES];
    logic [N_SRC*NB_SEL-1:0]        r_fwdSel;
    logic [NB_CNT-1:0]              r_stallCount;

    logic [N_SRC-1:0][NB_SEL-1:0]   w_hitStage;
    logic [N_SRC-1:0]               w_hitLoadUse;
    logic [NB_REG-1:0]              w_rs;
    logic                           w_stall;
    logic                           w_issue;

    // Walk from the oldest matchable entry to the youngest so the youngest match overwrites;
    // the last entry retires this cycle and the register file bypasses it, so it is skipped.
    always_comb begin
        w_hitStage   = '0;
        w_hitLoadUse = '0;
        w_rs         = '0;
        for (int k = 0; k < N_SRC; k++) begin
            w_rs = i_rs_from_ID[k*NB_REG +: NB_REG];
            for (int j = N_STAGES - 2; j >= 0; j--) begin
                if (r_sb[j].regWrite && (r_sb[j].rd == w_rs) && (w_rs != '0) && i_src_used[k]) begin
                    w_hitStage[k]   = NB_SEL'(j + 1);
                    w_hitLoadUse[k] = r_sb[j].memRead && ((j + 1) < LOAD_STAGE);
                end
            end
        end
    end

    assign w_stall = i_valid_ID & ~i_flush & ~i_rst & (|w_hitLoadUse);
    assign w_issue = i_valid_ID & ~i_flush & ~w_stall;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int j = 0; j < N_STAGES; j++) begin
                r_sb[j] <= '0;
            end
            r_fwdSel <= '0;
        end else begin
            for (int j = N_STAGES - 1; j > 0; j--) begin
                r_sb[j] <= r_sb[j-1];
            end
            if (w_issue) begin
                r_sb[0]  <= '{rd: i_rd_from_ID, regWrite: i_RegWrite_from_ID, memRead: i_MemRead_from_ID};
                r_fwdSel <= w_hitStage;
            end else begin
                r_sb[0]  <= '0;
                r_fwdSel <= '0;
            end
        end
    end

    // Saturating stall counter: sticks at all-ones instead of wrapping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stallCount <= '0;
        end else if (w_stall && (r_stallCount != '1)) begin
            r_stallCount <= r_stallCount + 1'b1;
        end
    end

    assign o_stall       = w_stall;
    assign o_fwd_sel     = r_fwdSel;
    assign o_stall_count = r_stallCount;

endmodule

// File: doc/hazard_forwarding_scoreboard.md
Name: hazard_forwarding_scoreboard

Overview:
- Parametrised successor to the EX-stage forwarding unit.
- Internally tracks destination register, RegWrite and MemRead for every in-flight instruction in a shift-register scoreboard of N_STAGES entries (stage 0 = EX, 1 = M, 2 = WB by default).
- Produces registered per-operand forwarding selects that enter EX together with the issuing instruction, for N_SRC source operands.
- Detects load-use hazards with a configurable load latency, stalls ID/IF, inserts bubbles, honours flushes, and keeps a saturating stall counter.

Parameters:
- NB_REG, 5, register index width.
- N_SRC, 2, number of source operands per instruction.
- N_STAGES, 3, scoreboard depth (EX..WB).
- LOAD_STAGE, 2, first stage index whose load data may be forwarded.
- NB_CNT, 16, stall counter width.
- NB_SEL (localparam), clog2(N_STAGES+1), forwarding select width.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid_ID  input  1  ID holds a valid instruction.
- i_rs_from_ID  input  N_SRC*NB_REG  packed source registers; operand k is at bits [k*NB_REG +: NB_REG].
- i_src_used  input  N_SRC  operand k is actually read.
- i_rd_from_ID  input  NB_REG  destination register of the ID instruction.
- i_RegWrite_from_ID  input  1  ID instruction writes the register file.
- i_MemRead_from_ID  input  1  ID instruction is a load.
- i_flush  input  1  squash the ID instruction (branch/jump redirect).
- o_stall  output  1  hold PC and IF/ID; combinational.
- o_fwd_sel  output  N_SRC*NB_SEL  registered select per operand; 0 = register file, s = stage s result.
- o_stall_count  output  NB_CNT  saturating count of stall cycles.

Behaviour:
Reset:
- i_rst asserted: all scoreboard entries invalid (rd=0, RegWrite=0, MemRead=0), o_fwd_sel=0, o_stall_count=0.
- o_stall=0 while reset is asserted.
- Asynchronous assertion takes effect immediately, including mid-stall.

Issue condition:
- issue = i_valid_ID & ~i_flush & ~o_stall.

Match:
- For operand k, match on pre-shift entries j in 0..N_STAGES-2 where all hold: entry RegWrite=1, entry rd == rs_k, rs_k != 0, i_src_used[k]=1.
- Only the youngest (lowest j) matching entry counts.
- Entry N_STAGES-1 retires this cycle; the register file provides write-before-read bypass for it, so it is never matched.

Load-use stall:
- o_stall = i_valid_ID & ~i_flush & (some operand's youngest match has MemRead=1 and j+1 < LOAD_STAGE).
- With defaults: a load in EX followed immediately by a dependent instruction causes exactly one stall cycle.

Clock edge (rising, not in reset):
- Entries shift: entry j+1 <= entry j, and entry N_STAGES-1 is dropped.
- If issue: entry 0 <= {i_rd_from_ID, i_RegWrite_from_ID, i_MemRead_from_ID}, and o_fwd_sel[k] <= j+1 of the youngest match, else 0.
- Otherwise (stall, flush or invalid): entry 0 <= bubble, and all o_fwd_sel <= 0.
- A bubble entry never matches.

Simultaneous events:
- Flush has priority over stall: o_stall=0, a bubble is inserted, and the counter does not increment.
- A hazard in both operands produces a single stall, not two.

Counter:
- o_stall_count increments on each edge where o_stall=1.
- Holds at 2^NB_CNT-1; no wrap.

Width rules:
- rd=0 never causes forwarding or a stall.
- NB_SEL must represent N_STAGES-1; LOAD_STAGE must be ≤ N_STAGES-1.

Test Plan:
Defaults are used unless noted.
1. Reset check: assert i_rst mid-run with a stall active -> o_fwd_sel=0, o_stall=0, o_stall_count=0 immediately; first issue after release sees no matches.
2. ALU dependency: issue add rd=3 (RegWrite=1), next cycle issue rs0=3, rs1=7 -> after the edge o_fwd_sel op0=1, op1=0; no stall.
3. Youngest wins and distance 2:
   - Issue rd=4, then rd=4, then rs0=4 -> sel 1.
   - Issue rd=6, then a NOP, then rs1=6 -> sel 2.
4. Load-use: issue lw rd=5, next cycle ID rs0=5 -> o_stall=1 for exactly one cycle and EX receives a bubble with sel 0. The next cycle issues with sel op0=2 and o_stall_count=1. Repeat with both operands = 5 -> still one stall.
5. Register zero and unused operands:
   - lw rd=0 then rs0=0 -> no stall, sel 0.
   - lw rd=8 then rs1=8 with i_src_used[1]=0 -> no stall, sel 0.
6. Flush and saturation:
   - Load-use pair with i_flush=1 in the hazard cycle -> o_stall=0, bubble inserted, counter unchanged.
   - NB_CNT=2 with 5 stalls -> o_stall_count holds at 3.
